// File: rtl/hdmi_scanout_ctrl.sv
// Video scan-out controller: raster timing generator driving pixel/FIFO strobes,
// plus a fill-FIFO sequencer that turns line events into DDR burst requests.
module hdmi_scanout_ctrl #(
   parameter int VRES    = 720,
   parameter int HFP     = 110,
   parameter int HSYNC_W = 40,
   parameter int HBP     = 220,
   parameter int VFP     = 5,
   parameter int VSYNC_W = 5,
   parameter int VBP     = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        start_fill,
   input  logic [10:0] hres,
   input  logic [31:0] frame_base_addr,
   input  logic [31:0] line_stride,
   input  logic [31:0] bytes_per_pixel,
   input  logic [31:0] color,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hsync,
   output logic        vsync,
   output logic        ve,
   output logic        read_fifo,
   output logic        read_go,
   output logic        read_next_line,
   output logic        read_next_chunk,
   output logic        read_done,
   output logic [31:0] ddr_addr_to_read,
   output logic        go_fill_fifo
);

   localparam logic [11:0] H_BLANK     = 12'(HFP + HSYNC_W + HBP);
   localparam logic [11:0] HFP_C       = 12'(HFP);
   localparam logic [11:0] HSYNC_C     = 12'(HSYNC_W);
   localparam logic [11:0] VRES_C      = 12'(VRES);
   localparam logic [11:0] VRES_LAST   = 12'(VRES - 1);
   localparam logic [11:0] VSYNC_START = 12'(VRES + VFP);
   localparam logic [11:0] VSYNC_END   = 12'(VRES + VFP + VSYNC_W);
   localparam logic [11:0] V_LAST      = 12'(VRES + VFP + VSYNC_W + VBP - 1);

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } seq_state_t;

   logic        running_reg;
   logic [11:0] h_reg;
   logic [11:0] v_reg;

   logic [11:0] hres_ext;
   logic [11:0] h_last;
   logic [11:0] line_end;
   logic [11:0] chunk_end;
   logic [11:0] hsync_start;
   logic [11:0] hsync_end;
   logic        active_line;

   assign hres_ext    = {1'b0, hres};
   assign h_last      = hres_ext + H_BLANK - 12'd1;
   assign line_end    = hres_ext - 12'd1;
   assign chunk_end   = {2'b00, hres[10:1]} - 12'd1;
   assign hsync_start = hres_ext + HFP_C;
   assign hsync_end   = hsync_start + HSYNC_C;
   assign active_line = v_reg < VRES_C;

   // Every raster output is a pure decode of the counters, so none adds latency.
   assign ve              = running_reg && (h_reg < hres_ext) && active_line;
   assign read_fifo       = ve;
   assign {red, green, blue} = ve ? color[31:8] : 24'd0;
   assign hsync           = running_reg && (h_reg >= hsync_start) && (h_reg < hsync_end);
   assign vsync           = running_reg && (v_reg >= VSYNC_START) && (v_reg < VSYNC_END);
   assign read_next_line  = running_reg && (h_reg == line_end) && (v_reg < VRES_LAST);
   assign read_done       = running_reg && (h_reg == line_end) && (v_reg == VRES_LAST);
   assign read_next_chunk = running_reg && (h_reg == chunk_end) && active_line;
   assign read_go         = !running_reg && start;

   always_ff @(posedge clock) begin
      if (reset) begin
         running_reg <= 1'b0;
         h_reg       <= 12'd0;
         v_reg       <= 12'd0;
      end else if (!running_reg) begin
         if (start) begin
            running_reg <= 1'b1;
         end
      end else if (h_reg == h_last) begin
         h_reg <= 12'd0;
         v_reg <= (v_reg == V_LAST) ? 12'd0 : v_reg + 12'd1;
      end else begin
         h_reg <= h_reg + 12'd1;
      end
   end

   seq_state_t  seq_state_reg;
   logic [31:0] ddr_addr_reg;
   logic        go_fill_reg;
   logic [31:0] stride_bytes;
   logic        kick;

   assign stride_bytes     = line_stride * bytes_per_pixel;
   assign kick             = start_fill || read_go;
   assign ddr_addr_to_read = ddr_addr_reg;
   assign go_fill_fifo     = go_fill_reg;

   // A kick always re-primes at the frame base, even when it lands on a line event.
   always_ff @(posedge clock) begin
      if (reset) begin
         seq_state_reg <= S_IDLE;
         ddr_addr_reg  <= 32'd0;
         go_fill_reg   <= 1'b0;
      end else begin
         go_fill_reg <= 1'b0;
         case (seq_state_reg)
            S_IDLE: begin
               if (kick) begin
                  ddr_addr_reg  <= frame_base_addr;
                  go_fill_reg   <= 1'b1;
                  seq_state_reg <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (kick || read_done) begin
                  ddr_addr_reg <= frame_base_addr;
                  go_fill_reg  <= 1'b1;
               end else if (read_next_line) begin
                  ddr_addr_reg <= ddr_addr_reg + stride_bytes;
                  go_fill_reg  <= 1'b1;
               end
            end
            default: seq_state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hdmi_scanout_ctrl.sv
// Randomized bench for hdmi_scanout_ctrl against a frame-time reference model
// (pixel position derived from elapsed cycles, fill addresses from line events).
module tb_hdmi_scanout_ctrl;

   localparam int VRES    = 6;
   localparam int VFP     = 2;
   localparam int VSYNC_W = 2;
   localparam int VBP     = 3;
   localparam int VTOTAL  = VRES + VFP + VSYNC_W + VBP;
   localparam int HFP     = 110;
   localparam int HSYNC_W = 40;
   localparam int HBP     = 220;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start_fill = 1'b0;
   logic [10:0] hres = 11'd1280;
   logic [31:0] frame_base_addr = 32'd0;
   logic [31:0] line_stride = 32'd0;
   logic [31:0] bytes_per_pixel = 32'd0;
   logic [31:0] color = 32'd0;
   logic [7:0]  red, green, blue;
   logic        hsync, vsync, ve, read_fifo, read_go;
   logic        read_next_line, read_next_chunk, read_done, go_fill_fifo;
   logic [31:0] ddr_addr_to_read;

   hdmi_scanout_ctrl #(
      .VRES(VRES), .HFP(HFP), .HSYNC_W(HSYNC_W), .HBP(HBP),
      .VFP(VFP), .VSYNC_W(VSYNC_W), .VBP(VBP)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .start_fill(start_fill),
      .hres(hres), .frame_base_addr(frame_base_addr), .line_stride(line_stride),
      .bytes_per_pixel(bytes_per_pixel), .color(color),
      .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
      .ve(ve), .read_fifo(read_fifo), .read_go(read_go),
      .read_next_line(read_next_line), .read_next_chunk(read_next_chunk),
      .read_done(read_done), .ddr_addr_to_read(ddr_addr_to_read),
      .go_fill_fifo(go_fill_fifo)
   );

   initial forever #5 clock = ~clock;

   logic [32:0] obs_vec;
   assign obs_vec = {red, green, blue, hsync, vsync, ve, read_fifo, read_go,
                     read_next_line, read_next_chunk, read_done, go_fill_fifo};

   int n_checks = 0;
   int n_fail = 0;

   // Reference model state
   bit          m_running = 0;
   bit          m_active = 0;
   bit          m_go = 0;
   logic [31:0] m_addr = 32'd0;
   int          m_t = 0;

   logic [32:0] exp_vec;
   logic [31:0] exp_addr;
   bit          e_ve, e_hs, e_vs, e_nl, e_done, e_chunk, e_go;
   int          e_h, e_v;

   function automatic int htotal();
      return int'(hres) + HFP + HSYNC_W + HBP;
   endfunction

   function automatic bit nl_due();
      int h, v;
      h = m_t % htotal();
      v = (m_t / htotal()) % VTOTAL;
      return m_running && (h == int'(hres) - 1) && (v < VRES - 1);
   endfunction

   // Drives one cycle of inputs, leaves the model's expectations for it in exp_*,
   // then advances the model past the coming clock edge.
   task automatic drive_cycle(input bit st, input bit sf, input bit rs, input logic [31:0] col);
      int ht, h, v;
      bit kick;
      logic [31:0] step;
      @(negedge clock);
      start = st;
      start_fill = sf;
      reset = rs;
      color = col;
      #1;
      ht = htotal();
      h = m_t % ht;
      v = (m_t / ht) % VTOTAL;
      e_h = h;
      e_v = v;
      e_ve    = m_running && h < int'(hres) && v < VRES;
      e_hs    = m_running && h >= int'(hres) + HFP && h < int'(hres) + HFP + HSYNC_W;
      e_vs    = m_running && v >= VRES + VFP && v < VRES + VFP + VSYNC_W;
      e_nl    = m_running && h == int'(hres) - 1 && v < VRES - 1;
      e_done  = m_running && h == int'(hres) - 1 && v == VRES - 1;
      e_chunk = m_running && h == int'(hres) / 2 - 1 && v < VRES;
      e_go    = !m_running && st;
      exp_vec = {e_ve ? col[31:8] : 24'd0, e_hs, e_vs, e_ve, e_ve, e_go,
                 e_nl, e_chunk, e_done, m_go};
      exp_addr = m_addr;
      if (rs) begin
         m_running = 0;
         m_t = 0;
         m_active = 0;
         m_addr = 32'd0;
         m_go = 0;
      end else begin
         kick = sf || e_go;
         step = line_stride * bytes_per_pixel;
         m_go = 0;
         if (kick) begin
            m_addr = frame_base_addr;
            m_go = 1;
            m_active = 1;
         end else if (m_active && e_done) begin
            m_addr = frame_base_addr;
            m_go = 1;
         end else if (m_active && e_nl) begin
            m_addr = m_addr + step;
            m_go = 1;
         end
         if (m_running) m_t++;
         else if (st) m_running = 1;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive_cycle(0, 1'($urandom % 2), 1, $urandom);
         if (i > 0) begin
            n_checks++;
            if (obs_vec !== 33'd0) begin
               n_fail++;
               $display("FAIL reset_outputs: got %h expected 0", obs_vec);
            end
            n_checks++;
            if (ddr_addr_to_read !== 32'd0) begin
               n_fail++;
               $display("FAIL reset_addr: got %h expected 0", ddr_addr_to_read);
            end
         end
      end
   endtask

   task automatic test_start();
      hres = 11'd1280;
      frame_base_addr = 32'hA800_0000;
      line_stride = 32'd1280;
      bytes_per_pixel = 32'd4;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(0, 0, 0, $urandom);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h expected %h", obs_vec, exp_vec);
         end
      end
      drive_cycle(1, 0, 0, $urandom);
      n_checks++;
      if (read_go !== 1'b1) begin
         n_fail++;
         $display("FAIL start_read_go: got %b expected 1", read_go);
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
         n_fail++;
         $display("FAIL start_outputs: got %h expected %h", obs_vec, exp_vec);
      end
   endtask

   task automatic test_line0();
      logic [31:0] col = 32'h1122_3300;
      int ve_cnt = 0, hs_cnt = 0, hs_first = -1, nl_h = -1, chunk_h = -1;
      bit prev_nl = 0;
      for (int i = 0; i < htotal(); i++) begin
         drive_cycle(1'($urandom % 2), 0, 0, col);
         if (i == 0) begin
            n_checks++;
            if (go_fill_fifo !== 1'b1 || ddr_addr_to_read !== 32'hA800_0000 || ve !== 1'b1) begin
               n_fail++;
               $display("FAIL first_pixel: got go=%b addr=%h ve=%b expected go=1 addr=a8000000 ve=1",
                        go_fill_fifo, ddr_addr_to_read, ve);
            end
         end
         if (prev_nl) begin
            n_checks++;
            if (go_fill_fifo !== 1'b1 || ddr_addr_to_read !== 32'hA800_1400) begin
               n_fail++;
               $display("FAIL line1_addr: got go=%b addr=%h expected go=1 addr=a8001400",
                        go_fill_fifo, ddr_addr_to_read);
            end
         end
         n_checks++;
         if (obs_vec !== exp_vec || ddr_addr_to_read !== exp_addr) begin
            n_fail++;
            $display("FAIL line0_outputs h=%0d: got %h/%h expected %h/%h",
                     e_h, obs_vec, ddr_addr_to_read, exp_vec, exp_addr);
         end
         if (ve === 1'b1) ve_cnt++;
         if (hsync === 1'b1) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = e_h;
         end
         if (read_next_line === 1'b1) nl_h = e_h;
         if (read_next_chunk === 1'b1) chunk_h = e_h;
         prev_nl = (read_next_line === 1'b1);
         if (e_ve) col = col + 32'h100;
      end
      n_checks++;
      if (ve_cnt != 1280 || hs_cnt != 40 || hs_first != 1390) begin
         n_fail++;
         $display("FAIL line0_counts: got ve=%0d hs=%0d hs_first=%0d expected 1280/40/1390",
                  ve_cnt, hs_cnt, hs_first);
      end
      n_checks++;
      if (nl_h != 1279 || chunk_h != 639) begin
         n_fail++;
         $display("FAIL line0_pulses: got nl_h=%0d chunk_h=%0d expected 1279/639", nl_h, chunk_h);
      end
   endtask

   task automatic test_frame();
      int ht = htotal();
      int nl_cnt = 0, done_cnt = 0, vs_cnt = 0, done_t = -1, last_nl_t = -1, bad_gap = 0;
      int cur_t;
      bit prev_done = 0, wrap_ok = 0;
      while (m_t < ht * VTOTAL + 2) begin
         cur_t = m_t;
         drive_cycle(1'($urandom % 2), 0, 0, $urandom);
         n_checks++;
         if (obs_vec !== exp_vec || ddr_addr_to_read !== exp_addr) begin
            n_fail++;
            $display("FAIL frame_outputs v=%0d h=%0d: got %h/%h expected %h/%h",
                     e_v, e_h, obs_vec, ddr_addr_to_read, exp_vec, exp_addr);
         end
         if (prev_done) begin
            n_checks++;
            if (go_fill_fifo !== 1'b1 || ddr_addr_to_read !== 32'hA800_0000) begin
               n_fail++;
               $display("FAIL done_prefetch: got go=%b addr=%h expected go=1 addr=a8000000",
                        go_fill_fifo, ddr_addr_to_read);
            end
         end
         if (read_next_line === 1'b1) begin
            nl_cnt++;
            if (last_nl_t >= 0 && cur_t - last_nl_t != ht) bad_gap++;
            last_nl_t = cur_t;
         end
         if (read_done === 1'b1) begin
            done_cnt++;
            done_t = cur_t;
         end
         if (vsync === 1'b1) vs_cnt++;
         if (cur_t == ht * VTOTAL && ve === 1'b1) wrap_ok = 1;
         prev_done = (read_done === 1'b1);
      end
      n_checks++;
      if (nl_cnt != VRES - 2 || done_cnt != 1 || bad_gap != 0) begin
         n_fail++;
         $display("FAIL frame_line_pulses: got nl=%0d done=%0d bad_gap=%0d expected %0d/1/0",
                  nl_cnt, done_cnt, bad_gap, VRES - 2);
      end
      n_checks++;
      if (done_t != (VRES - 1) * 1650 + 1279 || vs_cnt != VSYNC_W * 1650 || !wrap_ok) begin
         n_fail++;
         $display("FAIL frame_timing: got done_t=%0d vs=%0d wrap=%0d expected %0d/%0d/1",
                  done_t, vs_cnt, wrap_ok, (VRES - 1) * 1650 + 1279, VSYNC_W * 1650);
      end
   endtask

   task automatic test_kick_collision();
      int budget = 4 * htotal();
      while (!nl_due() && budget > 0) begin
         drive_cycle(0, 0, 0, $urandom);
         budget--;
      end
      n_checks++;
      if (budget == 0) begin
         n_fail++;
         $display("FAIL collision_wait: got timeout expected read_next_line");
      end
      drive_cycle(0, 1, 0, $urandom);
      n_checks++;
      if (read_next_line !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_nl: got %b expected 1", read_next_line);
      end
      drive_cycle(0, 0, 0, $urandom);
      n_checks++;
      if (go_fill_fifo !== 1'b1 || ddr_addr_to_read !== frame_base_addr) begin
         n_fail++;
         $display("FAIL collision_reload: got go=%b addr=%h expected go=1 addr=%h",
                  go_fill_fifo, ddr_addr_to_read, frame_base_addr);
      end
      drive_cycle(0, 0, 0, $urandom);
      n_checks++;
      if (go_fill_fifo !== 1'b0) begin
         n_fail++;
         $display("FAIL collision_single_pulse: got %b expected 0", go_fill_fifo);
      end
   endtask

   task automatic test_reset_midline();
      int budget = 4 * htotal();
      while (budget > 0 && !(m_t % htotal() == int'(hres) / 2 &&
                             (m_t / htotal()) % VTOTAL < VRES)) begin
         drive_cycle(0, 0, 0, $urandom);
         budget--;
      end
      drive_cycle(0, 0, 1, $urandom);
      n_checks++;
      if (obs_vec !== exp_vec || ve !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_cycle: got %h ve=%b expected %h ve=1", obs_vec, ve, exp_vec);
      end
      drive_cycle(0, 0, 0, $urandom);
      n_checks++;
      if (obs_vec !== 33'd0 || ddr_addr_to_read !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_midline: got %h/%h expected 0/0", obs_vec, ddr_addr_to_read);
      end
      for (int i = 0; i < 4; i++) begin
         drive_cycle(0, 0, 0, $urandom);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h expected %h", obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_fill_before_start();
      frame_base_addr = $urandom;
      drive_cycle(0, 1, 0, $urandom);
      n_checks++;
      if (obs_vec !== exp_vec) begin
         n_fail++;
         $display("FAIL prime_cycle: got %h expected %h", obs_vec, exp_vec);
      end
      drive_cycle(0, 0, 0, $urandom);
      n_checks++;
      if (go_fill_fifo !== 1'b1 || ddr_addr_to_read !== frame_base_addr || ve !== 1'b0) begin
         n_fail++;
         $display("FAIL prime_addr: got go=%b addr=%h ve=%b expected go=1 addr=%h ve=0",
                  go_fill_fifo, ddr_addr_to_read, ve, frame_base_addr);
      end
      for (int i = 0; i < 5; i++) begin
         drive_cycle(0, 0, 0, $urandom);
         n_checks++;
         if (obs_vec !== exp_vec || ddr_addr_to_read !== exp_addr || ve !== 1'b0) begin
            n_fail++;
            $display("FAIL prime_idle: got %h/%h expected %h/%h",
                     obs_vec, ddr_addr_to_read, exp_vec, exp_addr);
         end
      end
   endtask

   task automatic test_random_kicks();
      int cycles;
      drive_cycle(0, 0, 1, $urandom);
      hres = 11'(2 * $urandom_range(2, 20));
      frame_base_addr = $urandom;
      line_stride = $urandom;
      bytes_per_pixel = $urandom_range(1, 8);
      drive_cycle(0, 0, 1, $urandom);
      drive_cycle(1, 0, 0, $urandom);
      cycles = 2 * htotal() * VTOTAL + 40;
      for (int i = 0; i < cycles; i++) begin
         if ($urandom % 50 == 0) line_stride = $urandom;
         if ($urandom % 50 == 0) bytes_per_pixel = $urandom;
         drive_cycle(1'($urandom % 2), 1'($urandom % 6 == 0), 0, $urandom);
         n_checks++;
         if (obs_vec !== exp_vec || ddr_addr_to_read !== exp_addr) begin
            n_fail++;
            $display("FAIL random_kicks hres=%0d v=%0d h=%0d: got %h/%h expected %h/%h",
                     hres, e_v, e_h, obs_vec, ddr_addr_to_read, exp_vec, exp_addr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_line0();
      test_frame();
      test_kick_collision();
      test_reset_midline();
      test_fill_before_start();
      test_random_kicks();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
